// File: rtl/arbitro_memoria_pkg.sv
// Shared types and constants for the two-requester Memoria arbiter.
// Holds the FSM state encoding, requester indices and the latency-counter load helper.
package arb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;
    localparam int   MAX_LAT = 7;
    localparam int   CNT_W   = 3;

    // Counter preload for a given read latency, clamped into the legal 1..MAX_LAT range.
    function automatic logic [CNT_W-1:0] lat_load(input int lat);
        if (lat < 1) begin
            return {CNT_W{1'b0}};
        end else if (lat > MAX_LAT) begin
            return CNT_W'(MAX_LAT - 1);
        end else begin
            return CNT_W'(lat - 1);
        end
    endfunction

endpackage

// File: rtl/arbitro_memoria_rr_sel.sv
// Combinational round-robin picker for two requesters.
// On a tie the requester that did not own the memory last time wins.
module arb_rr_sel
    import arb_mem_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_owner,
    output logic o_any
);

    // Owner selection: single requester wins outright, a tie goes to the non-last owner.
    always_comb begin
        o_owner = REQ_CPU;
        o_any   = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_owner = ~i_last;
        end else if (i_req1) begin
            o_owner = REQ_AUX;
        end else begin
            o_owner = REQ_CPU;
        end
    end

endmodule

// File: rtl/arbitro_memoria.sv
// Arbiter/sequencer sharing the single-port Memoria between the CPU and an auxiliary master.
// Latches the winner's access, waits out the read latency and returns a one-cycle ack.
module arbitro_memoria
    import arb_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
)
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              gnt,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

    arb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_gnt;
    logic              r_busy;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic [DATA_W-1:0] r_rdata;
    logic              w_owner;
    logic              w_any;

    arb_rr_sel u_sel (
        .i_req0  (req0),
        .i_req1  (req1),
        .i_last  (r_gnt),
        .o_owner (w_owner),
        .o_any   (w_any)
    );

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign gnt      = r_gnt;
    assign busy     = r_busy;
    assign mem_wr   = r_mem_wr;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign rdata    = r_rdata;

    // Access sequencer: grant, drive the memory, wait the read latency, acknowledge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_gnt      <= REQ_AUX;
            r_busy     <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= {ADDR_W{1'b0}};
            r_mem_din  <= {DATA_W{1'b0}};
            r_rdata    <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    if (w_any) begin
                        r_state    <= ACCESS;
                        r_busy     <= 1'b1;
                        r_gnt      <= w_owner;
                        r_mem_wr   <= (w_owner == REQ_AUX) ? wr1    : wr0;
                        r_mem_addr <= (w_owner == REQ_AUX) ? addr1  : addr0;
                        r_mem_din  <= (w_owner == REQ_AUX) ? wdata1 : wdata0;
                    end else begin
                        r_busy   <= 1'b0;
                        r_mem_wr <= 1'b0;
                    end
                end
                ACCESS: begin
                    r_mem_wr <= 1'b0;
                    if (r_mem_wr) begin
                        r_state <= RESP;
                        r_ack0  <= (r_gnt == REQ_CPU);
                        r_ack1  <= (r_gnt == REQ_AUX);
                    end else begin
                        r_cnt   <= LAT_LOAD;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    r_mem_wr <= 1'b0;
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_rdata <= mem_dout;
                        r_state <= RESP;
                        r_ack0  <= (r_gnt == REQ_CPU);
                        r_ack1  <= (r_gnt == REQ_AUX);
                    end else begin
                        r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                RESP: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_mem_wr <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: one instance with MEM_LAT=1, one with MEM_LAT=3,
// each attached to a small behavioural Memoria model.
module tb_arbitro_memoria;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A (MEM_LAT=1)
    logic        a_rst_n, a_req0, a_wr0, a_ack0, a_req1, a_wr1, a_ack1, a_gnt, a_busy, a_mem_wr;
    logic [31:0] a_addr0, a_wdata0, a_addr1, a_wdata1, a_rdata, a_mem_addr, a_mem_din, a_mem_dout;
    // Instance B (MEM_LAT=3)
    logic        b_rst_n, b_req0, b_wr0, b_ack0, b_req1, b_wr1, b_ack1, b_gnt, b_busy, b_mem_wr;
    logic [31:0] b_addr0, b_wdata0, b_addr1, b_wdata1, b_rdata, b_mem_addr, b_mem_din, b_mem_dout;

    arbitro_memoria #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_a (
        .Clk(clk), .Reset(a_rst_n),
        .req0(a_req0), .wr0(a_wr0), .addr0(a_addr0), .wdata0(a_wdata0), .ack0(a_ack0),
        .req1(a_req1), .wr1(a_wr1), .addr1(a_addr1), .wdata1(a_wdata1), .ack1(a_ack1),
        .rdata(a_rdata), .gnt(a_gnt), .busy(a_busy),
        .mem_addr(a_mem_addr), .mem_wr(a_mem_wr), .mem_din(a_mem_din), .mem_dout(a_mem_dout)
    );

    arbitro_memoria #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut_b (
        .Clk(clk), .Reset(b_rst_n),
        .req0(b_req0), .wr0(b_wr0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0),
        .req1(b_req1), .wr1(b_wr1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1),
        .rdata(b_rdata), .gnt(b_gnt), .busy(b_busy),
        .mem_addr(b_mem_addr), .mem_wr(b_mem_wr), .mem_din(b_mem_din), .mem_dout(b_mem_dout)
    );

    // Memoria models: synchronous write, read data MEM_LAT edges after the address
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic [31:0] b_p0, b_p1;
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h00;
    logic [31:0] pl_data = 32'h0;

    always @(posedge clk) begin
        if (pl_en) mem_a[pl_addr] <= pl_data;
        else if (a_mem_wr) mem_a[a_mem_addr[7:0]] <= a_mem_din;
        a_mem_dout <= mem_a[a_mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (pl_en) mem_b[pl_addr] <= pl_data;
        else if (b_mem_wr) mem_b[b_mem_addr[7:0]] <= b_mem_din;
        b_p0       <= mem_b[b_mem_addr[7:0]];
        b_p1       <= b_p0;
        b_mem_dout <= b_p1;
    end

    typedef struct {
        logic        who;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ack0;
        logic        exp_ack1;
        logic        exp_gnt;
        int          exp_lat;
        int          exp_wp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    int lat, wp, nack, ack0_seen;
    logic got;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 1'b0, 3, 0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 32'h20, 32'h12345678, 1'b1, 1'b0, 1'b0, 2, 1, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,        1'b1, 1'b0, 1'b0, 3, 0, 32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 32'h30, 32'hA5A55A5A, 1'b0, 1'b1, 1'b1, 2, 1, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h30, 32'h0,        1'b0, 1'b1, 1'b1, 3, 0, 32'hA5A55A5A};
        vecs[5] = '{1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 1'b1, 1'b1, 3, 0, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b1, 32'h44, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 2, 1, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 1'b1, 1'b1, 3, 0, 32'h0000FFFF};

        a_rst_n = 1'b0; a_req0 = 1'b0; a_wr0 = 1'b0; a_addr0 = 32'h0; a_wdata0 = 32'h0;
        a_req1 = 1'b0; a_wr1 = 1'b0; a_addr1 = 32'h0; a_wdata1 = 32'h0;
        b_rst_n = 1'b0; b_req0 = 1'b0; b_wr0 = 1'b0; b_addr0 = 32'h0; b_wdata0 = 32'h0;
        b_req1 = 1'b0; b_wr1 = 1'b0; b_addr1 = 32'h0; b_wdata1 = 32'h0;

        @(negedge clk);
        preload(8'h10, 32'hDEADBEEF);
        preload(8'h44, 32'hCAFEF00D);
        preload(8'h40, 32'h13579BDF);
        preload(8'h50, 32'h2468ACE0);

        // Reset values
        chk("rst_ack0", a_ack0, 32'h0);
        chk("rst_ack1", a_ack1, 32'h0);
        chk("rst_mem_wr", a_mem_wr, 32'h0);
        chk("rst_mem_addr", a_mem_addr, 32'h0);
        chk("rst_mem_din", a_mem_din, 32'h0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_gnt", a_gnt, 32'h1);
        chk("rst_busy", a_busy, 32'h0);
        chk("rst_b_gnt", b_gnt, 32'h1);
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);

        // Table: single-requester transactions on instance A
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].who) begin
                a_req1 = 1'b1; a_wr1 = vecs[i].wr; a_addr1 = vecs[i].addr; a_wdata1 = vecs[i].wdata;
            end else begin
                a_req0 = 1'b1; a_wr0 = vecs[i].wr; a_addr0 = vecs[i].addr; a_wdata0 = vecs[i].wdata;
            end
            lat = 0; wp = 0; got = 1'b0;
            while (!got && lat < 20) begin
                @(negedge clk);
                lat++;
                if (a_mem_wr) wp++;
                if (a_ack0 | a_ack1) got = 1'b1;
            end
            chk($sformatf("v%0d_ack0", i), a_ack0, vecs[i].exp_ack0);
            chk($sformatf("v%0d_ack1", i), a_ack1, vecs[i].exp_ack1);
            chk($sformatf("v%0d_gnt", i), a_gnt, vecs[i].exp_gnt);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_wr_pulses", i), wp, vecs[i].exp_wp);
            if (!vecs[i].wr) chk($sformatf("v%0d_rdata", i), a_rdata, vecs[i].exp_rdata);
            a_req0 = 1'b0; a_req1 = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_idle_busy", i), a_busy, 32'h0);
            chk($sformatf("v%0d_idle_ack", i), a_ack0 | a_ack1, 32'h0);
        end

        // Both requesters from reset, held high: grants alternate 0,1,0,1
        a_rst_n = 1'b0;
        @(negedge clk);
        a_rst_n = 1'b1;
        a_req0 = 1'b1; a_wr0 = 1'b0; a_addr0 = 32'h10;
        a_req1 = 1'b1; a_wr1 = 1'b0; a_addr1 = 32'h44;
        nack = 0; lat = 0;
        while (nack < 4 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (a_ack0 | a_ack1) begin
                chk($sformatf("rr_owner%0d", nack), a_ack1, 32'(nack % 2));
                chk($sformatf("rr_gnt%0d", nack), a_gnt, 32'(nack % 2));
                chk($sformatf("rr_onehot%0d", nack), a_ack0 & a_ack1, 32'h0);
                nack++;
            end
        end
        a_req0 = 1'b0; a_req1 = 1'b0;
        chk("rr_ack_count", nack, 32'd4);
        @(negedge clk);

        // Aux arrives while CPU owns; aux served next even with req0 still high
        a_req0 = 1'b1; a_wr0 = 1'b0; a_addr0 = 32'h10;
        @(negedge clk);
        a_req1 = 1'b1; a_wr1 = 1'b0; a_addr1 = 32'h44;
        nack = 0; lat = 0;
        while (nack < 2 && lat < 30) begin
            @(negedge clk);
            lat++;
            if (a_ack0 | a_ack1) begin
                if (nack == 0) begin
                    chk("pend_first_ack0", a_ack0, 32'h1);
                    chk("pend_first_ack1", a_ack1, 32'h0);
                    chk("pend_first_rdata", a_rdata, 32'hDEADBEEF);
                end else begin
                    chk("pend_second_ack1", a_ack1, 32'h1);
                    chk("pend_second_gnt", a_gnt, 32'h1);
                    chk("pend_second_rdata", a_rdata, 32'h0000FFFF);
                    a_req0 = 1'b0; a_req1 = 1'b0;
                end
                nack++;
            end
        end
        a_req0 = 1'b0; a_req1 = 1'b0;
        chk("pend_ack_count", nack, 32'd2);

        // MEM_LAT=3 aux read; address change after grant is ignored
        b_req1 = 1'b1; b_wr1 = 1'b0; b_addr1 = 32'h40;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) b_addr1 = 32'h50;
            if (b_ack0 | b_ack1) got = 1'b1;
            else begin
                chk($sformatf("lat3_addr_c%0d", lat), b_mem_addr, 32'h40);
                chk($sformatf("lat3_wr_c%0d", lat), b_mem_wr, 32'h0);
            end
        end
        chk("lat3_ack1", b_ack1, 32'h1);
        chk("lat3_ack0", b_ack0, 32'h0);
        chk("lat3_lat", lat, 32'd5);
        chk("lat3_rdata", b_rdata, 32'h13579BDF);
        b_req1 = 1'b0;
        @(negedge clk);

        // Reset during WAIT of a CPU read drops the access without ack
        b_req0 = 1'b1; b_wr0 = 1'b0; b_addr0 = 32'h50;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_busy_before", b_busy, 32'h1);
        b_rst_n = 1'b0;
        #1;
        chk("rstmid_busy", b_busy, 32'h0);
        chk("rstmid_mem_wr", b_mem_wr, 32'h0);
        chk("rstmid_ack0", b_ack0, 32'h0);
        chk("rstmid_gnt", b_gnt, 32'h1);
        chk("rstmid_mem_addr", b_mem_addr, 32'h0);
        b_req0 = 1'b0;
        ack0_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) b_rst_n = 1'b1;
            if (b_ack0) ack0_seen++;
        end
        chk("rstmid_no_ack", ack0_seen, 32'd0);
        b_req0 = 1'b1; b_wr0 = 1'b0; b_addr0 = 32'h50;
        lat = 0; got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (b_ack0 | b_ack1) got = 1'b1;
        end
        chk("reissue_ack0", b_ack0, 32'h1);
        chk("reissue_lat", lat, 32'd5);
        chk("reissue_rdata", b_rdata, 32'h2468ACE0);
        b_req0 = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
